// File: rtl/ray_pkg.sv
// Shared types and constants for the frame-scan ray generator.
package ray_pkg;

   // Ray origin fields {ox, oy, oz}
   localparam int unsigned OX_W     = 10;
   localparam int unsigned OY_W     = 9;
   localparam int unsigned OZ_W     = 9;
   localparam int unsigned ORIGIN_W = OX_W + OY_W + OZ_W;

   // Ray direction fields {dx, dy, dz}, two's complement
   localparam int unsigned DX_W  = 11;
   localparam int unsigned DY_W  = 10;
   localparam int unsigned DZ_W  = 10;
   localparam int unsigned DIR_W = DX_W + DY_W + DZ_W;

   // Scan, camera and frame-buffer widths
   localparam int unsigned X_W     = 10;
   localparam int unsigned Y_W     = 9;
   localparam int unsigned FOCAL_W = 10;
   localparam int unsigned COLOR_W = 12;
   localparam int unsigned ADDR_W  = 19;

   localparam logic [COLOR_W-1:0] BLACK = 12'h000;
   localparam logic [COLOR_W-1:0] WHITE = 12'hFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic [OX_W-1:0] ox;
      logic [OY_W-1:0] oy;
      logic [OZ_W-1:0] oz;
   } origin_t;

   typedef struct packed {
      logic signed [DX_W-1:0] dx;
      logic signed [DY_W-1:0] dy;
      logic signed [DZ_W-1:0] dz;
   } dir_t;

endpackage

// File: rtl/ray_dir_calc.sv
// Pixel-to-direction mapping: screen-centred x/y offsets plus focal depth.
module ray_dir_calc
   import ray_pkg::*;
#(
   parameter int unsigned H_RES = 640,
   parameter int unsigned V_RES = 480
) (
   input  logic [X_W-1:0]       x,
   input  logic [Y_W-1:0]       y,
   input  logic [FOCAL_W-2:0]   focal_lo,
   output dir_t                 dir_c
);

   // dx grows to the right, dy grows upward, dz is always non-negative
   always_comb begin
      dir_c.dx = DX_W'(x) - DX_W'(H_RES / 2);
      dir_c.dy = DY_W'(V_RES / 2) - DY_W'(y);
      dir_c.dz = {1'b0, focal_lo};
   end

endmodule

// File: rtl/ray_gen.sv
// Frame-scan ray generator: one primary ray per pixel in raster order,
// tracer colour written back to the frame buffer at y*H_RES+x.
// Optional build macro RAY_GEN_TIMEOUT_EN: a WAIT that sees no tracer
// return for TIMEOUT cycles writes black and moves on.
module ray_gen
   import ray_pkg::*;
#(
   parameter int unsigned H_RES   = 640,
   parameter int unsigned V_RES   = 480,
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ORIGIN_W-1:0] cam_origin,
   input  logic [FOCAL_W-1:0]  focal,
   output logic [ORIGIN_W-1:0] init,
   output logic [DIR_W-1:0]    dir,
   output logic                ray_valid,
   input  logic                ray_ready,
   input  logic                tracer_ret,
   input  logic [COLOR_W-1:0]  trace_color,
   output logic                pix_we,
   output logic [ADDR_W-1:0]   pix_addr,
   output logic [COLOR_W-1:0]  pix_data,
   output logic                busy,
   output logic                frame_done
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

   state_t                state_q, state_nxt;
   logic [X_W-1:0]        x_q, x_nxt;
   logic [Y_W-1:0]        y_q, y_nxt;
   logic [ORIGIN_W-1:0]   origin_q, origin_nxt;
   logic [FOCAL_W-2:0]    focal_q, focal_nxt;
   logic [ADDR_W-1:0]     addr_nxt;
   logic                  last_pix_c;
   logic                  timeout_c;
   dir_t                  dir_c;

   // Only focal[8:0] reaches dz; the MSB is architecturally dropped
   logic unused_focal_msb;
   assign unused_focal_msb = focal[FOCAL_W-1];

   assign last_pix_c = (x_q == X_LAST) && (y_q == Y_LAST);

`ifdef RAY_GEN_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] wait_cnt_q;

   // Counts WAIT cycles; held at zero outside WAIT so each ray starts fresh
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else if (state_q != ST_WAIT) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_q + TO_W'(1);
      end
   end

   assign timeout_c = (state_q == ST_WAIT) && (wait_cnt_q == TO_W'(TIMEOUT - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign timeout_c      = 1'b0;
`endif

   // Direction for the pixel about to be issued
   ray_dir_calc #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_dir_calc (
      .x        (x_nxt),
      .y        (y_nxt),
      .focal_lo (focal_nxt),
      .dir_c    (dir_c)
   );

   // Next-state, scan position and address counter
   always_comb begin
      state_nxt  = state_q;
      x_nxt      = x_q;
      y_nxt      = y_q;
      origin_nxt = origin_q;
      focal_nxt  = focal_q;
      addr_nxt   = pix_addr;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               origin_nxt = cam_origin;
               focal_nxt  = focal[FOCAL_W-2:0];
               x_nxt      = '0;
               y_nxt      = '0;
               addr_nxt   = '0;
               state_nxt  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ray_valid && ray_ready) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tracer_ret || timeout_c) begin
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (last_pix_c) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_ISSUE;
               addr_nxt  = pix_addr + ADDR_W'(1);
               if (x_q == X_LAST) begin
                  x_nxt = '0;
                  y_nxt = y_q + Y_W'(1);
               end else begin
                  x_nxt = x_q + X_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and scan registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         origin_q <= '0;
         focal_q  <= '0;
      end else begin
         state_q  <= state_nxt;
         x_q      <= x_nxt;
         y_q      <= y_nxt;
         origin_q <= origin_nxt;
         focal_q  <= focal_nxt;
      end
   end

   // Registered outputs, decoded from the state being entered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init       <= '0;
         dir        <= '0;
         ray_valid  <= 1'b0;
         pix_we     <= 1'b0;
         pix_addr   <= '0;
         pix_data   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         ray_valid  <= (state_nxt == ST_ISSUE);
         pix_we     <= (state_nxt == ST_WRITE);
         busy       <= (state_nxt != ST_IDLE);
         frame_done <= (state_nxt == ST_DONE);
         pix_addr   <= addr_nxt;
         if (state_nxt == ST_ISSUE) begin
            init <= origin_nxt;
            dir  <= dir_c;
         end
         if (state_q == ST_WAIT) begin
            if (tracer_ret) begin
               pix_data <= trace_color;
            end else if (timeout_c) begin
               pix_data <= BLACK;
            end
         end
      end
   end

endmodule

// File: tb/tb_ray_gen.sv
// Self-checking bench for ray_gen: tracer model plus frame scoreboard,
// direction table, and hand sequences for reset and stall corners.
// Build with RAY_GEN_TIMEOUT_EN to also cover the WAIT timeout.
module tb_ray_gen;
   import ray_pkg::*;

   localparam int unsigned H     = 4;
   localparam int unsigned V     = 2;
   localparam int          N_PIX = int'(H * V);
   localparam int unsigned TMO   = 8;
`ifdef RAY_GEN_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
   localparam int DLY_HI = 11;
`else
   localparam bit TMO_EN = 1'b0;
   localparam int DLY_HI = 5;
`endif

   int total = 0;
   int bad   = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                start, ray_ready, tracer_ret;
   logic [ORIGIN_W-1:0] cam_origin, init;
   logic [FOCAL_W-1:0]  focal;
   logic [DIR_W-1:0]    dir;
   logic                ray_valid, pix_we, busy, frame_done;
   logic [ADDR_W-1:0]   pix_addr;
   logic [COLOR_W-1:0]  trace_color, pix_data;

   logic                b_start, b_ready, b_ret;
   logic [ORIGIN_W-1:0] b_origin, b_init;
   logic [FOCAL_W-1:0]  b_focal;
   logic [DIR_W-1:0]    b_dir;
   logic                b_valid, b_we, b_busy, b_done;
   logic [ADDR_W-1:0]   b_addr;
   logic [COLOR_W-1:0]  b_color, b_data;

   logic [X_W-1:0]      dc_x;
   logic [Y_W-1:0]      dc_y;
   logic [FOCAL_W-2:0]  dc_focal;
   dir_t                dc_dir;

   ray_gen #(.H_RES(H), .V_RES(V), .TIMEOUT(TMO)) u_dut (
      .clk(clk), .rst(rst), .start(start), .cam_origin(cam_origin), .focal(focal),
      .init(init), .dir(dir), .ray_valid(ray_valid), .ray_ready(ray_ready),
      .tracer_ret(tracer_ret), .trace_color(trace_color), .pix_we(pix_we),
      .pix_addr(pix_addr), .pix_data(pix_data), .busy(busy), .frame_done(frame_done)
   );

   ray_gen #(.H_RES(640), .V_RES(480), .TIMEOUT(1023)) u_big (
      .clk(clk), .rst(rst), .start(b_start), .cam_origin(b_origin), .focal(b_focal),
      .init(b_init), .dir(b_dir), .ray_valid(b_valid), .ray_ready(b_ready),
      .tracer_ret(b_ret), .trace_color(b_color), .pix_we(b_we),
      .pix_addr(b_addr), .pix_data(b_data), .busy(b_busy), .frame_done(b_done)
   );

   ray_dir_calc #(.H_RES(640), .V_RES(480)) u_dc (
      .x(dc_x), .y(dc_y), .focal_lo(dc_focal), .dir_c(dc_dir)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drives one frame on u_dut acting as the tracer; scoreboards every cycle.
   task automatic run_frame(input logic [ORIGIN_W-1:0] org, input logic [FOCAL_W-1:0] foc,
                            input int st_lo, input int st_hi, input int dl_lo, input int dl_hi,
                            input bit white, input bit noise, output int cycles);
      int wr_idx, ray_idx, stall_left, wsamp, dly, px, py;
      bit exp_valid, exp_we, exp_done, waiting, nxt_valid, nxt_we, nxt_done, finished;
      logic [COLOR_W-1:0] exp_data, col;
      dir_t d;
      wr_idx = 0; ray_idx = 0; waiting = 1'b0; wsamp = 0; dly = 0;
      exp_valid = 1'b1; exp_we = 1'b0; exp_done = 1'b0; finished = 1'b0;
      exp_data = '0; cycles = 0;
      stall_left = int'($urandom_range(st_hi, st_lo));
      @(posedge clk); #1;
      start = 1'b1; cam_origin = org; focal = foc;
      @(posedge clk); #1;
      start = 1'b0; cam_origin = ORIGIN_W'($urandom); focal = FOCAL_W'($urandom);
      while (!finished && cycles < 3000) begin
         chk("ray_valid", ray_valid, exp_valid);
         chk("pix_we", pix_we, exp_we);
         if (exp_we) begin
            chk("pix_addr", pix_addr, wr_idx);
            chk("pix_data", pix_data, exp_data);
         end
         chk("frame_done", frame_done, exp_done);
         chk("busy", busy, 1);
         if (exp_done) begin
            finished = 1'b1;
            break;
         end
         ray_ready = 1'b0; tracer_ret = 1'b0; start = 1'b0;
         trace_color = COLOR_W'($urandom);
         nxt_valid = exp_valid; nxt_we = 1'b0; nxt_done = 1'b0;
         if (exp_we) begin
            wr_idx++;
            if (wr_idx == N_PIX) nxt_done = 1'b1;
            else begin
               nxt_valid  = 1'b1;
               stall_left = int'($urandom_range(st_hi, st_lo));
            end
         end
         if (exp_valid) begin
            px = ray_idx % int'(H);
            py = ray_idx / int'(H);
            d  = dir;
            chk("init", init, org);
            chk("dir_dx", int'($signed(d.dx)), px - int'(H / 2));
            chk("dir_dy", int'($signed(d.dy)), int'(V / 2) - py);
            chk("dir_dz", int'($signed(d.dz)), int'(foc) % 512);
            if (stall_left > 0) begin
               stall_left--;
               if (noise && $urandom_range(1, 0) == 1) begin
                  tracer_ret = 1'b1;
                  start      = 1'b1;
                  cam_origin = ORIGIN_W'($urandom);
               end
            end else begin
               ray_ready = 1'b1;
               nxt_valid = 1'b0;
               waiting   = 1'b1;
               wsamp     = 0;
               dly       = int'($urandom_range(dl_hi, dl_lo));
               ray_idx++;
            end
         end else if (waiting) begin
            wsamp++;
            col = white ? WHITE : COLOR_W'($urandom);
            if (wsamp == dly + 1) begin
               tracer_ret  = 1'b1;
               trace_color = col;
               nxt_we      = 1'b1;
               exp_data    = col;
               waiting     = 1'b0;
            end else if (TMO_EN && wsamp == int'(TMO)) begin
               nxt_we   = 1'b1;
               exp_data = BLACK;
               waiting  = 1'b0;
            end
         end
         if (noise && !exp_valid) ray_ready = 1'($urandom);
         exp_valid = nxt_valid; exp_we = nxt_we; exp_done = nxt_done;
         cycles++;
         @(posedge clk); #1;
      end
      if (!finished) chk("frame_not_finished", 0, 1);
      ray_ready = 1'b0; tracer_ret = 1'b0; start = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ray_valid"}, ray_valid, 0);
      chk({tag, "_pix_we"}, pix_we, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_init"}, init, 0);
      chk({tag, "_dir"}, dir, 0);
      chk({tag, "_pix_addr"}, pix_addr, 0);
      chk({tag, "_pix_data"}, pix_data, 0);
   endtask

   typedef struct {
      int x; int y; int f; int dx; int dy; int dz;
   } dc_vec_t;

   initial begin
      dc_vec_t vt[6];
      int cyc, stray, acc;
      bit ret_next, hit;
      dir_t d;

      vt[0] = '{0,    0,   200,  -320,  240, 200};
      vt[1] = '{639,  479, 200,   319, -239, 200};
      vt[2] = '{320,  240, 0,       0,    0,   0};
      vt[3] = '{1023, 511, 511,   703, -271, 511};
      vt[4] = '{5,    300, 77,   -315,  -60,  77};
      vt[5] = '{639,  0,   300,   319,  240, 300};

      rst = 1'b1; start = 1'b0; ray_ready = 1'b0; tracer_ret = 1'b0;
      cam_origin = '0; focal = '0; trace_color = '0;
      b_start = 1'b0; b_ready = 1'b0; b_ret = 1'b0;
      b_origin = '0; b_focal = '0; b_color = '0;
      dc_x = '0; dc_y = '0; dc_focal = '0;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("por");
      rst = 1'b0;

      // Idle with no start
      stray = 0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (ray_valid || pix_we || busy) stray++;
      end
      chk("idle_activity", stray, 0);

      // Direction table on the standalone mapper
      for (int i = 0; i < 6; i++) begin
         dc_x = X_W'(vt[i].x);
         dc_y = Y_W'(vt[i].y);
         dc_focal = (FOCAL_W - 1)'(vt[i].f);
         #1;
         chk("dc_dx", int'($signed(dc_dir.dx)), vt[i].dx);
         chk("dc_dy", int'($signed(dc_dir.dy)), vt[i].dy);
         chk("dc_dz", int'($signed(dc_dir.dz)), vt[i].dz);
      end

      // Full-size instance: first two rays and the first write
      @(posedge clk); #1;
      b_start = 1'b1; b_origin = 28'h1234567; b_focal = 10'd200;
      @(posedge clk); #1;
      b_start = 1'b0; b_origin = '0; b_focal = '0;
      chk("big_valid0", b_valid, 1);
      d = b_dir;
      chk("big_init", b_init, 28'h1234567);
      chk("big_dx0", int'($signed(d.dx)), -320);
      chk("big_dy0", int'($signed(d.dy)), 240);
      chk("big_dz0", int'($signed(d.dz)), 200);
      b_ready = 1'b1;
      @(posedge clk); #1;
      b_ready = 1'b0; b_ret = 1'b1; b_color = 12'h3C7;
      @(posedge clk); #1;
      b_ret = 1'b0;
      chk("big_we", b_we, 1);
      chk("big_addr0", b_addr, 0);
      chk("big_data0", b_data, 12'h3C7);
      @(posedge clk); #1;
      d = b_dir;
      chk("big_valid1", b_valid, 1);
      chk("big_dx1", int'($signed(d.dx)), -319);
      chk("big_dy1", int'($signed(d.dy)), 240);

      // Best case: ready held, white returned one cycle after acceptance
      run_frame(28'hABCDEF1, 10'd200, 0, 0, 0, 0, 1'b1, 1'b0, cyc);
      chk("best_case_cycles", cyc, 24);

      // Five-cycle ready stall on every ray
      run_frame(28'h0F0F0F0, 10'd700, 5, 5, 0, 0, 1'b0, 1'b0, cyc);
      chk("stall_cycles", cyc, 64);

      // Randomized frames with stalls, delays and ignored stray strobes
      for (int k = 0; k < 6; k++) begin
         run_frame(ORIGIN_W'($urandom), FOCAL_W'($urandom), 0, 3, 0, DLY_HI, 1'b0, 1'b1, cyc);
      end

      // Reset while waiting on pixel 3, then a late tracer return
      @(posedge clk); #1;
      start = 1'b1; cam_origin = 28'h7654321; focal = 10'd33;
      @(posedge clk); #1;
      start = 1'b0;
      acc = 0; ret_next = 1'b0; hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tracer_ret = 1'b0; ray_ready = 1'b0;
         if (ret_next) begin
            if (acc == 4) begin
               hit = 1'b1;
               rst = 1'b1;
            end else begin
               tracer_ret  = 1'b1;
               trace_color = 12'h5A5;
            end
            ret_next = 1'b0;
         end else if (ray_valid) begin
            ray_ready = 1'b1;
            acc++;
            ret_next = 1'b1;
         end
         if (!hit) begin
            @(posedge clk); #1;
         end
      end
      chk("rst_in_wait_reached", hit, 1);
      #1;
      chk_reset_vals("midrst");
      @(posedge clk); #1;
      rst = 1'b0; tracer_ret = 1'b1; trace_color = 12'hABC;
      stray = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         tracer_ret = 1'b0;
         if (pix_we || busy || ray_valid) stray++;
      end
      chk("late_ret_ignored", stray, 0);
      run_frame(28'h1111111, 10'd5, 0, 1, 0, 2, 1'b0, 1'b0, cyc);

      // Start coincident with reset
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      chk("start_with_rst_busy", busy, 0);
      chk("start_with_rst_valid", ray_valid, 0);

`ifdef RAY_GEN_TIMEOUT_EN
      // Tracer never answers: every pixel blackened after the timeout
      run_frame(28'h2222222, 10'd9, 0, 0, 1000, 1000, 1'b0, 1'b0, cyc);
      chk("timeout_cycles", cyc, 80);
      // Return lands exactly on the timeout cycle: its colour wins
      run_frame(28'h3333333, 10'd10, 0, 0, int'(TMO) - 1, int'(TMO) - 1, 1'b0, 1'b0, cyc);
      chk("tie_cycles", cyc, 80);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
